// File: rtl/mux_sched_pkg.sv
// Shared types for the 4-lane round-robin mux scheduler.
package mux_sched_pkg;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

  function automatic logic [NREQ-1:0] onehot(input idx_t i);
    logic [NREQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first asserted request scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import mux_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output logic            any,
  output idx_t            idx
);

  always_comb begin
    any = |req;
    idx = ptr;
    // Walk from the lowest priority upward so the closest lane to ptr wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr + idx_t'(k)]) idx = ptr + idx_t'(k);
    end
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin owner of the shared 4:1 mux: grants one lane, drives the select,
// and registers the selected lane onto z behind a valid/ready output stage.
module mux4_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] c,
  input  logic               out_ready,
  output logic [NREQ-1:0]    gnt,
  output idx_t               s,
  output logic [DW-1:0]      z,
  output logic               out_valid
);

  localparam int            HW        = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  sched_state_t    state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  idx_t            s_q, s_d;
  logic [DW-1:0]   z_q, z_d;
  logic            ov_q, ov_d;
  logic [HW-1:0]   hold_q, hold_d;
  idx_t            ptr_q, ptr_d;

  logic [DW-1:0]   lane [NREQ];
  idx_t            pick_ptr;
  idx_t            pick_idx;
  logic            pick_any;
  logic            beat, load, release_now;

  always_comb begin
    for (int i = 0; i < NREQ; i++) lane[i] = c[i*DW +: DW];
  end

  // While granted, the picker already looks from the lane after s so a release
  // can re-grant in the same cycle with the rotated priority.
  assign pick_ptr = (state_q == GRANT) ? s_q + idx_t'(1) : ptr_q;

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign beat        = ov_q && out_ready;
  assign load        = !ov_q || out_ready;
  assign release_now = (beat && (hold_q == HOLD_LAST)) || (!req[s_q] && load);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    z_d     = z_q;
    ov_d    = ov_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = onehot(pick_idx);
          s_d     = pick_idx;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ov_d   = 1'b0;
          ptr_d  = pick_ptr;
          hold_d = '0;
          // A sole requester still asserting is picked again at once.
          if (pick_any) begin
            gnt_d = onehot(pick_idx);
            s_d   = pick_idx;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          if (load) begin
            ov_d = req[s_q];
            z_d  = lane[s_q];
          end
          if (beat) hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      z_q     <= '0;
      ov_q    <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      z_q     <= z_d;
      ov_q    <= ov_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign s         = s_q;
  assign z         = z_q;
  assign out_valid = ov_q;

endmodule
